// File: rtl/stream_sink_chk.sv
// Stream sink: LFSR-paced ready, packet assembly with length/XOR-sum/count, forced close at MAX_PKT.
// Optional source hold-rule checker enabled by defining SINK_HOLD_CHECK_EN.
module stream_sink_chk #(
  parameter int          LEN     = 8,
  parameter int          MAX_PKT = 16,
  parameter logic [7:0]  SEED    = 8'hA5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           valid,
  input  logic           last,
  input  logic [LEN-1:0] data,
  input  logic           stall_en,
  output logic           ready,
  output logic           pkt_done,
  output logic [7:0]     pkt_len,
  output logic [LEN-1:0] pkt_sum,
  output logic [15:0]    pkt_cnt,
  output logic           ovf,
  output logic           proto_err
);

  typedef enum logic [0:0] {IDLE = 1'b0, RECV = 1'b1} state_t;

  localparam logic [7:0] MAX_BEATS = 8'(MAX_PKT);

  state_t         state_q;
  logic [7:0]     lfsr_q, lfsr_d;
  logic [7:0]     beat_q, beat_d;
  logic [LEN-1:0] acc_q, acc_d;
  logic           ready_q, pkt_done_q, ovf_q;
  logic [7:0]     pkt_len_q;
  logic [LEN-1:0] pkt_sum_q;
  logic [15:0]    pkt_cnt_q;
  logic           fire;
  logic           at_max;

  always_comb begin
    fire   = valid & ready_q;
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    beat_d = (state_q == IDLE) ? 8'd1 : beat_q + 8'd1;
    acc_d  = (state_q == IDLE) ? data : acc_q ^ data;
    at_max = (beat_d == MAX_BEATS);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      lfsr_q     <= SEED;
      beat_q     <= 8'd0;
      acc_q      <= '0;
      ready_q    <= 1'b0;
      pkt_done_q <= 1'b0;
      pkt_len_q  <= 8'd0;
      pkt_sum_q  <= '0;
      pkt_cnt_q  <= 16'd0;
      ovf_q      <= 1'b0;
    end else begin
      lfsr_q     <= lfsr_d;
      // Ready uses the pre-advance LFSR value.
      ready_q    <= stall_en ? (lfsr_q[1:0] != 2'b00) : 1'b1;
      pkt_done_q <= 1'b0;
      if (fire) begin
        if (last || at_max) begin
          pkt_done_q <= 1'b1;
          pkt_len_q  <= beat_d;
          pkt_sum_q  <= acc_d;
          pkt_cnt_q  <= pkt_cnt_q + 16'd1;
          ovf_q      <= ~last;
          state_q    <= IDLE;
          beat_q     <= 8'd0;
          acc_q      <= '0;
        end else begin
          state_q    <= RECV;
          beat_q     <= beat_d;
          acc_q      <= acc_d;
        end
      end
    end
  end

  assign ready    = ready_q;
  assign pkt_done = pkt_done_q;
  assign pkt_len  = pkt_len_q;
  assign pkt_sum  = pkt_sum_q;
  assign pkt_cnt  = pkt_cnt_q;
  assign ovf      = ovf_q;

`ifdef SINK_HOLD_CHECK_EN
  logic           armed_q;
  logic           hold_last_q;
  logic [LEN-1:0] hold_data_q;
  logic           proto_err_q;

  // A stalled offer arms the check; the source must repeat it unchanged next cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      armed_q     <= 1'b0;
      hold_last_q <= 1'b0;
      hold_data_q <= '0;
      proto_err_q <= 1'b0;
    end else begin
      armed_q     <= valid & ~ready_q;
      hold_last_q <= last;
      hold_data_q <= data;
      if (armed_q && (!valid || data != hold_data_q || last != hold_last_q))
        proto_err_q <= 1'b1;
    end
  end

  assign proto_err = proto_err_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_stream_sink_chk.sv
// Self-checking bench for stream_sink_chk: randomized packets against a packet-level reference model.
module tb_stream_sink_chk;
  localparam int         LEN     = 8;
  localparam int         MAX_PKT = 16;
  localparam logic [7:0] SEED    = 8'hA5;
  localparam int         W       = LEN + 9;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           valid = 1'b0;
  logic           last = 1'b0;
  logic [LEN-1:0] data = '0;
  logic           stall_en = 1'b0;
  logic           ready, pkt_done, ovf, proto_err;
  logic [7:0]     pkt_len;
  logic [LEN-1:0] pkt_sum;
  logic [15:0]    pkt_cnt;

  stream_sink_chk #(.LEN(LEN), .MAX_PKT(MAX_PKT), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .valid(valid), .last(last), .data(data),
    .stall_en(stall_en), .ready(ready), .pkt_done(pkt_done), .pkt_len(pkt_len),
    .pkt_sum(pkt_sum), .pkt_cnt(pkt_cnt), .ovf(ovf), .proto_err(proto_err)
  );

  // clock
  always #5 clk = ~clk;

  // reference model state
  logic [7:0]     m_lfsr;
  logic           m_ready, m_fired, m_closed, m_ovf, m_perr;
  logic [7:0]     m_len;
  logic [LEN-1:0] m_sum;
  int             m_cnt;
  logic [LEN-1:0] cur_q[$];
  logic [W-1:0]   exp_q[$];
  logic           m_arm, m_arm_last;
  logic [LEN-1:0] m_arm_data;
  logic           gaps;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model over the coming edge, then compare after the edge.
  task automatic tick();
    logic [LEN-1:0] s;
    logic [W-1:0]   rec;
    m_fired  = 1'b0;
    m_closed = 1'b0;
    if (!rst) begin
      m_lfsr = SEED; m_ready = 1'b0; m_cnt = 0; m_len = 0; m_sum = 0; m_ovf = 0;
      m_perr = 0; m_arm = 0;
      cur_q.delete();
    end else begin
`ifdef SINK_HOLD_CHECK_EN
      if (m_arm && (!valid || data != m_arm_data || last != m_arm_last)) m_perr = 1'b1;
`endif
      m_arm = valid && !m_ready;
      m_arm_data = data;
      m_arm_last = last;
      if (valid && m_ready) begin
        m_fired = 1'b1;
        cur_q.push_back(data);
        if (last || cur_q.size() == MAX_PKT) begin
          s = '0;
          foreach (cur_q[i]) s ^= cur_q[i];
          m_len = 8'(cur_q.size());
          m_sum = s;
          m_ovf = !last;
          m_cnt = (m_cnt + 1) % 65536;
          m_closed = 1'b1;
          exp_q.push_back({m_ovf, m_len, m_sum});
          cur_q.delete();
        end
      end
      m_ready = stall_en ? ((m_lfsr % 4) != 0) : 1'b1;
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
    @(posedge clk);
    #1;
    chk("ready", ready, m_ready);
    chk("pkt_done", pkt_done, m_closed);
    if (m_closed && exp_q.size() > 0) begin
      rec = exp_q.pop_front();
      chk("pkt_record", {ovf, pkt_len, pkt_sum}, rec);
    end
    chk("pkt_len_hold", pkt_len, m_len);
    chk("pkt_sum_hold", pkt_sum, m_sum);
    chk("ovf_hold", ovf, m_ovf);
    chk("pkt_cnt", pkt_cnt, m_cnt);
    chk("proto_err", proto_err, m_perr);
  endtask

  task automatic send_beat(input logic [LEN-1:0] d, input logic l);
    valid = 1'b1; data = d; last = l;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (m_fired) break;
    end
    chk("fire_timeout", m_fired, 1'b1);
    valid = 1'b0; last = 1'b0; data = LEN'($urandom_range(0, 255));
    if (gaps) repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic do_reset();
    rst = 1'b0; valid = 1'b0; last = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  initial begin
    logic exp_perr;
    int   n;
    gaps = 1'b0;

    // reset state
    do_reset();
    chk("rst_ready", ready, 1'b0);
    chk("rst_cnt", pkt_cnt, 16'd0);
    chk("rst_len", pkt_len, 8'd0);

    // ready rises on the second cycle, then a 3-beat packet
    tick();
    chk("ready_cycle2", ready, 1'b1);
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    send_beat(8'h33, 1'b1);
    chk("p3_len", pkt_len, 8'd3);
    chk("p3_sum", pkt_sum, 8'h00);
    chk("p3_cnt", pkt_cnt, 16'd1);

    // single-beat packet in IDLE
    send_beat(8'h5A, 1'b1);
    chk("p1_len", pkt_len, 8'd1);
    chk("p1_sum", pkt_sum, 8'h5A);
    chk("p1_ovf", ovf, 1'b0);

    // back-to-back single-beat packets
    send_beat(8'h01, 1'b1);
    send_beat(8'h02, 1'b1);

    // LFSR backpressure from reset, then 10 random packets
    stall_en = 1'b1;
    do_reset();
    repeat (64) tick();
    gaps = 1'b1;
    for (int p = 0; p < 10; p++) begin
      n = $urandom_range(1, 8);
      for (int b = 0; b < n; b++) send_beat(LEN'($urandom_range(0, 255)), b == n - 1);
    end
    tick();
    chk("cnt10", pkt_cnt, 16'd10);

    // overflow: 20 beats without last, then a closing beat
    stall_en = 1'b0;
    gaps = 1'b0;
    for (int b = 0; b < 20; b++) begin
      send_beat(8'h01, 1'b0);
      if (b == 15) begin
        chk("ovf_len", pkt_len, 8'd16);
        chk("ovf_flag", ovf, 1'b1);
        chk("ovf_sum", pkt_sum, 8'h00);
      end
    end
    send_beat(8'h01, 1'b1);
    chk("after_ovf_len", pkt_len, 8'd5);
    chk("after_ovf_flag", ovf, 1'b0);

    // reset during beat 2 of a packet
    send_beat(8'hAA, 1'b0);
    valid = 1'b1; data = 8'hBB; rst = 1'b0;
    tick();
    chk("midrst_done", pkt_done, 1'b0);
    chk("midrst_cnt", pkt_cnt, 16'd0);
    chk("midrst_sum", pkt_sum, 8'h00);
    rst = 1'b1; valid = 1'b0;
    tick();
    send_beat(8'h12, 1'b0);
    send_beat(8'h34, 1'b1);
    chk("midrst_len2", pkt_len, 8'd2);
    chk("midrst_cnt1", pkt_cnt, 16'd1);

    // hold-rule violation: offer while stalled, then drop valid
    stall_en = 1'b1;
    for (int i = 0; i < 64 && m_ready; i++) tick();
    chk("found_stall", m_ready, 1'b0);
    valid = 1'b1; data = 8'hC3; last = 1'b0;
    tick();
    valid = 1'b0;
    tick();
`ifdef SINK_HOLD_CHECK_EN
    exp_perr = 1'b1;
`else
    exp_perr = 1'b0;
`endif
    chk("hold_viol", proto_err, exp_perr);
    repeat (3) tick();
    chk("hold_sticky", proto_err, exp_perr);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule

// File: doc/stream_sink_chk.md
Name: stream_sink_chk

Overview:
- Downstream consumer for the random valid/ready/last byte source. It terminates the stream with an LFSR-driven ready pattern and assembles beats into packets.
- Per packet it reports length, XOR checksum and a packet count, plus a beat-overflow flag.
- Optionally checks source hold rules (valid/data stable while stalled).
- Used as the bench-side and on-chip sink for the source stage.

Parameters:
- LEN, 8, data width in bits.
- MAX_PKT, 16, maximum beats per packet before forced close (2..255).
- SEED, 8'hA5, LFSR reset value; must be nonzero.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-low (sampled low at posedge clk = reset).
- valid  input  1  source data valid.
- last  input  1  final beat of packet; qualified by valid.
- data  input  LEN  source data.
- stall_en  input  1  1 = pseudo-random backpressure; 0 = ready held high.
- ready  output  1  sink ready (registered).
- pkt_done  output  1  one-cycle pulse: packet closed.
- pkt_len  output  8  beat count of the last closed packet.
- pkt_sum  output  LEN  XOR of all data beats of the last closed packet.
- pkt_cnt  output  16  closed packets since reset; wraps 16'hFFFF -> 0.
- ovf  output  1  set with pkt_done when a packet was force-closed at MAX_PKT.
- proto_err  output  1  sticky hold-rule violation flag.

Behaviour:
- Reset (rst=0 at posedge clk) applies these values:
  - ready=0, pkt_done=0, pkt_len=0, pkt_sum=0, pkt_cnt=0, ovf=0, proto_err=0.
  - lfsr=SEED, state=IDLE, beat counter=0, accumulator=0.
  - Any partial packet is discarded.
- LFSR, 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1:
  - Advances every non-reset cycle.
  - New bit = lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3], shifted into bit 0.
- ready register:
  - Next value = 1 when stall_en=0.
  - Next value = (lfsr[1:0] != 2'b00) when stall_en=1, computed from the pre-advance lfsr.
  - First cycle after reset release: ready=0. Ready follows from the second cycle.
- fire = valid & ready. Only fire cycles consume a beat.
- State machine:
  - IDLE: no beats held. A fire with last=0 goes to RECV with beat=1 and acc=data.
  - IDLE, fire with last=1: single-beat packet closes, staying in IDLE.
  - RECV: each fire does beat+1 and acc^=data.
  - RECV, fire with last=1: close the packet and go to IDLE.
- Packet close (registered, visible the cycle after the closing fire):
  - pkt_done=1 for exactly one cycle.
  - pkt_len = beats including the closing beat.
  - pkt_sum = acc ^ closing data.
  - pkt_cnt+1.
  - ovf=0 on a normal close.
- Overflow:
  - If a fire with last=0 brings the beat count to MAX_PKT, close anyway with pkt_len=MAX_PKT and ovf=1 for that pulse.
  - Return to IDLE. The following beats start a new packet.
- last with valid=0 is ignored.
- pkt_len, pkt_sum and ovf hold their values between pulses.
- Back-to-back packets:
  - A close and the first beat of the next packet may fire on consecutive cycles; pkt_done pulses on consecutive cycles.
  - No bubble is required.
- Reset mid-packet: no pkt_done pulse, counters cleared, pkt_cnt=0.

Optional Feature:
- Macro: SINK_HOLD_CHECK_EN.
- When defined, the hold rules are registered. A cycle with valid=1 & ready=0 arms the check for the next cycle.
- In the armed cycle, either of these sets proto_err=1 (sticky until reset):
  - valid=0.
  - data or last differs from the armed cycle.
- The check disarms after a fire.
- When not defined: proto_err is tied to 0 and no check logic is generated.

Test Plan:
- Reset release, stall_en=0, 3-beat packet 8'h11, 8'h22, 8'h33 (last on 3rd):
  - ready=1 from cycle 2.
  - pkt_done one cycle after 3rd beat, pkt_len=3, pkt_sum=8'h00, pkt_cnt=1.
- Single beat 8'h5A with last=1 in IDLE -> pkt_len=1, pkt_sum=8'h5A, ovf=0.
- stall_en=1, SEED=8'hA5:
  - ready matches the reference LFSR model for 64 cycles.
  - 10 packets with random lengths 1..8 -> pkt_cnt=10; each pkt_len and pkt_sum match the model.
- 20 beats of 8'h01, no last, MAX_PKT=16:
  - pkt_done with pkt_len=16, ovf=1, pkt_sum=8'h00.
  - Remaining 4 beats followed by a last beat give pkt_len=5, ovf=0.
- Reset low during beat 2 of a packet:
  - No pkt_done; all outputs at reset values.
  - The next 2-beat packet gives pkt_len=2, pkt_cnt=1.
- With SINK_HOLD_CHECK_EN:
  - valid=1, ready=0, then valid dropped next cycle -> proto_err=1 and stays 1.
  - Without the macro, the same stimulus -> proto_err=0.
